bcd_digit_accum: RTL and testbench

BCD_DIGIT_ACCUM -- requirements
Module: bcd_digit_accum

---
 rtl/bcd_digit_accum.sv | 128 ++++++++++++
 tb/tb_bcd_digit_accum.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_accum.sv
// BCD keypad-style digit accumulator: collects up to MAX_DIGITS decimal digits
// MSD-first, supports backspace/clear, and commits the binary value on enter.
module bcd_digit_accum #(
    parameter int unsigned MAX_DIGITS = 2,
    parameter int unsigned BIN_W      = 6,
    parameter int unsigned MAX_VAL    = 60,
    localparam int unsigned CNT_W     = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       digit_in,
    input  logic             digit_valid,
    output logic             digit_ready,
    input  logic             backspace,
    input  logic             enter,
    input  logic             clear,
    output logic [BIN_W-1:0] bin_out,
    output logic             bin_valid,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] ndigits
);

    localparam int unsigned SUM_W = BIN_W + 4;

    typedef enum logic [1:0] {
        StIdle,
        StEntry,
        StDone,
        StErr
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [BIN_W-1:0]   r_acc;
    logic [BIN_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [BIN_W-1:0]   r_bin;
    logic [BIN_W-1:0]   w_bin_next;
    logic               r_bin_valid;
    logic               w_bin_valid_next;
    logic [1:0]         r_err_code;
    logic [1:0]         w_err_code_next;

    logic [SUM_W-1:0]   w_sum;
    logic               w_xfer;

    // Full-width sum so an out-of-range entry is caught rather than wrapped.
    assign w_sum = ({4'b0000, r_acc} * SUM_W'(10)) + {{BIN_W{1'b0}}, digit_in};

    assign digit_ready = rst_n
                       && ((r_state == StIdle) || (r_state == StEntry))
                       && (r_count < CNT_W'(MAX_DIGITS))
                       && !clear && !enter && !backspace;

    assign w_xfer = digit_valid && digit_ready;

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_count_next     = r_count;
        w_bin_next       = r_bin;
        w_bin_valid_next = 1'b0;
        w_err_code_next  = r_err_code;

        if (clear) begin
            w_state_next    = StIdle;
            w_acc_next      = '0;
            w_count_next    = '0;
            w_err_code_next = 2'b00;
        end else if (enter) begin
            if (r_state == StEntry) begin
                w_bin_next       = r_acc;
                w_bin_valid_next = 1'b1;
                w_state_next     = StDone;
            end else if (r_state == StIdle) begin
                w_state_next    = StErr;
                w_err_code_next = 2'b11;
            end
        end else if (backspace) begin
            if (r_state == StEntry) begin
                w_acc_next   = r_acc / BIN_W'(10);
                w_count_next = r_count - CNT_W'(1);
                if (r_count == CNT_W'(1)) begin
                    w_state_next = StIdle;
                end
            end
        end else if (w_xfer) begin
            if (digit_in > 4'd9) begin
                w_state_next    = StErr;
                w_err_code_next = 2'b01;
            end else if (w_sum > SUM_W'(MAX_VAL)) begin
                w_state_next    = StErr;
                w_err_code_next = 2'b10;
            end else begin
                w_acc_next   = w_sum[BIN_W-1:0];
                w_count_next = r_count + CNT_W'(1);
                w_state_next = StEntry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_count     <= '0;
            r_bin       <= '0;
            r_bin_valid <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_count     <= w_count_next;
            r_bin       <= w_bin_next;
            r_bin_valid <= w_bin_valid_next;
            r_err_code  <= w_err_code_next;
        end
    end

    assign bin_out   = r_bin;
    assign bin_valid = r_bin_valid;
    assign err       = (r_state == StErr);
    assign err_code  = r_err_code;
    assign ndigits   = r_count;

endmodule

// File: tb/tb_bcd_digit_accum.sv
// Directed, table-driven bench for bcd_digit_accum with hand-computed expectations
// plus hand-written sequences for same-cycle priority and asynchronous reset.
module tb_bcd_digit_accum;

    logic       clk;
    logic       rst_n;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;
    logic       backspace;
    logic       enter;
    logic       clear;
    logic [5:0] bin_out;
    logic       bin_valid;
    logic       err;
    logic [1:0] err_code;
    logic [1:0] ndigits;

    int checks;
    int failures;

    bcd_digit_accum #(
        .MAX_DIGITS (2),
        .BIN_W      (6),
        .MAX_VAL    (60)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .backspace   (backspace),
        .enter       (enter),
        .clear       (clear),
        .bin_out     (bin_out),
        .bin_valid   (bin_valid),
        .err         (err),
        .err_code    (err_code),
        .ndigits     (ndigits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       ent;
        logic       bs;
        logic       dv;
        logic [3:0] d;
        logic [5:0] e_bin;
        logic       e_bv;
        logic       e_err;
        logic [1:0] e_code;
        logic [1:0] e_nd;
        logic       e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic clr, input logic ent, input logic bs,
                                input logic dv, input logic [3:0] d,
                                input logic [5:0] e_bin, input logic e_bv,
                                input logic e_err, input logic [1:0] e_code,
                                input logic [1:0] e_nd, input logic e_rdy);
        vec_t v;
        v.clr = clr; v.ent = ent; v.bs = bs; v.dv = dv; v.d = d;
        v.e_bin = e_bin; v.e_bv = e_bv; v.e_err = e_err;
        v.e_code = e_code; v.e_nd = e_nd; v.e_rdy = e_rdy;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [5:0] e_bin, input logic e_bv,
                              input logic e_err, input logic [1:0] e_code,
                              input logic [1:0] e_nd, input logic e_rdy);
        chk({tag, "_bin"},   int'(bin_out),     int'(e_bin));
        chk({tag, "_bv"},    int'(bin_valid),   int'(e_bv));
        chk({tag, "_err"},   int'(err),         int'(e_err));
        chk({tag, "_code"},  int'(err_code),    int'(e_code));
        chk({tag, "_nd"},    int'(ndigits),     int'(e_nd));
        chk({tag, "_ready"}, int'(digit_ready), int'(e_rdy));
    endtask

    // Drive for one full cycle, then idle inputs and let outputs settle.
    task automatic step(input logic clr, input logic ent, input logic bs,
                        input logic dv, input logic [3:0] d);
        @(negedge clk);
        clear = clr; enter = ent; backspace = bs; digit_valid = dv; digit_in = d;
        @(posedge clk);
        #1;
        clear = 1'b0; enter = 1'b0; backspace = 1'b0; digit_valid = 1'b0; digit_in = 4'd0;
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        clear = 1'b0; enter = 1'b0; backspace = 1'b0; digit_valid = 1'b0; digit_in = 4'd0;

        //              clr ent bs dv  d      bin bv err code nd rdy
        // 4,2,enter -> 42
        vecs.push_back(mk(0, 0, 0, 1, 4'd4,  6'd0,  0, 0, 2'd0, 2'd1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 4'd2,  6'd0,  0, 0, 2'd0, 2'd2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0,  6'd42, 1, 0, 2'd0, 2'd2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0,  6'd42, 0, 0, 2'd0, 2'd2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0,  6'd42, 0, 0, 2'd0, 2'd0, 1));
        // 6,1 -> overflow; digit and enter ignored in ERR; clear exits
        vecs.push_back(mk(0, 0, 0, 1, 4'd6,  6'd42, 0, 0, 2'd0, 2'd1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 4'd1,  6'd42, 0, 1, 2'd2, 2'd1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'd3,  6'd42, 0, 1, 2'd2, 2'd1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0,  6'd42, 0, 1, 2'd2, 2'd1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0,  6'd42, 0, 0, 2'd0, 2'd0, 1));
        // non-BCD digit, then 5, bs, bs(ignored in IDLE), 3, enter -> 3
        vecs.push_back(mk(0, 0, 0, 1, 4'hB,  6'd42, 0, 1, 2'd1, 2'd0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0,  6'd42, 0, 0, 2'd0, 2'd0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 4'd5,  6'd42, 0, 0, 2'd0, 2'd1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4'd0,  6'd42, 0, 0, 2'd0, 2'd0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4'd0,  6'd42, 0, 0, 2'd0, 2'd0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 4'd3,  6'd42, 0, 0, 2'd0, 2'd1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0,  6'd3,  1, 0, 2'd0, 2'd1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0,  6'd3,  0, 0, 2'd0, 2'd0, 1));
        // empty enter; then 1,2,3(refused, no error), enter -> 12
        vecs.push_back(mk(0, 1, 0, 0, 4'd0,  6'd3,  0, 1, 2'd3, 2'd0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0,  6'd3,  0, 0, 2'd0, 2'd0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 4'd1,  6'd3,  0, 0, 2'd0, 2'd1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 4'd2,  6'd3,  0, 0, 2'd0, 2'd2, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'd3,  6'd3,  0, 0, 2'd0, 2'd2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0,  6'd12, 1, 0, 2'd0, 2'd2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0,  6'd12, 0, 0, 2'd0, 2'd0, 1));
        // MAX_VAL boundary: 60 is legal
        vecs.push_back(mk(0, 0, 0, 1, 4'd6,  6'd12, 0, 0, 2'd0, 2'd1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 4'd0,  6'd12, 0, 0, 2'd0, 2'd2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0,  6'd60, 1, 0, 2'd0, 2'd2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0,  6'd60, 0, 0, 2'd0, 2'd0, 1));
        // 5,7 -> bs leaves 5 -> 9 gives 59
        vecs.push_back(mk(0, 0, 0, 1, 4'd5,  6'd60, 0, 0, 2'd0, 2'd1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 4'd7,  6'd60, 0, 0, 2'd0, 2'd2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'd0,  6'd60, 0, 0, 2'd0, 2'd1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 4'd9,  6'd60, 0, 0, 2'd0, 2'd2, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'd0,  6'd59, 1, 0, 2'd0, 2'd2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0,  6'd59, 0, 0, 2'd0, 2'd0, 1));
        // priority: backspace beats digit, enter beats backspace and digit
        vecs.push_back(mk(0, 0, 0, 1, 4'd4,  6'd59, 0, 0, 2'd0, 2'd1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 4'd7,  6'd59, 0, 0, 2'd0, 2'd0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 4'd2,  6'd59, 0, 0, 2'd0, 2'd1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 4'd9,  6'd2,  1, 0, 2'd0, 2'd1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0,  6'd2,  0, 0, 2'd0, 2'd0, 1));

        // Reset state while rst_n is held low
        repeat (2) @(posedge clk);
        #1;
        check_outs("rst", 6'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", int'(digit_ready), 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].ent, vecs[i].bs, vecs[i].dv, vecs[i].d);
            check_outs($sformatf("v%0d", i), vecs[i].e_bin, vecs[i].e_bv, vecs[i].e_err,
                       vecs[i].e_code, vecs[i].e_nd, vecs[i].e_rdy);
        end

        // clear and enter together in ENTRY: clear wins, no commit
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
        check_outs("ce_d8", 6'd2, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        check_outs("ce_both", 6'd2, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("ce_no_pulse", int'(bin_valid), 0);

        // Asynchronous reset mid-entry, between clock edges
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        chk("mid_nd", int'(ndigits), 2);
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 6'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("async_rel_ready", int'(digit_ready), 1);

        // Reset during the bin_valid pulse suppresses it
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check_outs("pulse", 6'd7, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("pulse_rst", 6'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
        check_outs("post_rst", 6'd0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
